load_store_sequencer: RTL

Parametrised load/store control sequencer: on a start request it waits a programmable settle interval, loads a burst of words through a valid/ready input port into an internal buffer, then stores the burst out through a valid/ready output port in forward or reversed order. Successor to the fixed three-state wait/load/store controller. It adds configurable data width, burst length and wait interval, flow-controlled handshakes, a reversal mode and completion status. It sits between a producer and consumer in the datapath and owns the sequencing state.

---
 rtl/load_store_pkg.sv | 29 ++
 rtl/load_store_sequencer_if.sv | 23 ++
 rtl/load_store_sequencer_burst_buffer.sv | 25 ++
 rtl/load_store_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/load_store_pkg.sv
// Shared types for the load/store sequencer: state encoding and small helpers.
package load_store_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int min1_clog2(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Human-readable state name for log messages.
    function automatic string state_name(input logic [2:0] s);
        case (s)
            3'd0:    return "IDLE";
            3'd1:    return "WAIT";
            3'd2:    return "LOAD";
            3'd3:    return "STORE";
            3'd4:    return "DONE";
            default: return "ILLEGAL";
        endcase
    endfunction

endpackage

// File: rtl/load_store_sequencer_if.sv
// Producer-side and consumer-side valid/ready streams of the sequencer.
interface load_store_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // Environment side: drives load words and store backpressure.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/load_store_sequencer_burst_buffer.sv
// Burst storage: one synchronous write port, one combinational read port.
module burst_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Capture one load word per accepted handshake.
    // NOTE: storage has no reset; every word is written before it is read, and the output mux hides stale contents.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/load_store_sequencer.sv
// Load/store sequencer: settle wait, burst load into a buffer, then burst
// store in forward or reversed order, with a one-cycle completion pulse.
module load_store_sequencer
    import load_store_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int BURST_LEN   = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          reverse,
    load_store_sequencer_if.slave         bus,
    output logic                          busy,
    output logic                          done,
    output logic [2:0]                    state
);
    localparam int IDX_W  = min1_clog2(BURST_LEN);
    localparam int WCNT_W = min1_clog2(WAIT_CYCLES + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BURST_LEN - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               rev_q, rev_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               buf_we;
    logic [IDX_W-1:0]   rd_addr;
    logic [DATA_W-1:0]  rd_data;

    // Next-state, counter and registered-output computation.
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        rev_d   = rev_q;
        buf_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rev_d   = reverse;
                    idx_d   = '0;
                    wcnt_d  = '0;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_LOAD;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    wcnt_d  = '0;
                    state_d = ST_LOAD;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    buf_we = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_STORE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_STORE: begin
                if (out_valid_q && bus.out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = '0;
                wcnt_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_STORE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // Sequencer state and registered outputs, with synchronous reset.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wcnt_q      <= '0;
            rev_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            rev_q       <= rev_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr = rev_q ? (IDX_LAST - idx_q) : idx_q;

    burst_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (BURST_LEN),
        .AW     (IDX_W)
    ) u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (idx_q),
        .wdata (bus.in_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Outside STORE the data bus is forced to zero rather than exposing buffer contents.
    assign bus.out_data  = out_valid_q ? rd_data : '0;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign state         = state_q;
endmodule
